alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
- Operand-fetch stage directly upstream of the combinational ALU.
- Holds the 8-entry register file. Rd operands come from r4–r7 and rs operands from r0–r3.
- Sources the ALU carry/shift input f_in from R1[0], and writes the ALU result and flag back to the register file.
- Registers one instruction per cycle into an execute latch that drives the ALU, with stall, flush, and an operand bypass for back-to-back dependences.

Parameters:
- DW, 8, datapath width; ALU operands and register width.
- NREG, 8, register count; fixed at 8 (3-bit dest index).
- NOP_CMD, 4'b1111, ALU command driven when the execute latch holds a bubble.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  issue slot holds an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_cmd  in  4  ALU command.
- in_rd_idx  in  2  selects r(4+idx) as inA.
- in_rs_idx  in  2  selects r(idx) as inB when in_use_imm=0.
- in_imm  in  DW  immediate, used as inB when in_use_imm=1.
- in_use_imm  in  1  inB source select.
- in_wr_en  in  1  write ALU rslt back.
- in_dest  in  3  writeback register index.
- in_flag_wr  in  1  write ALU out to R1.
- ex_stall  in  1  downstream holds the execute latch.
- flush  in  1  squash the instruction being accepted this cycle.
- alu_cmd  out  4  to ALU.
- alu_a  out  DW  to ALU inA.
- alu_b  out  DW  to ALU inB.
- alu_fin  out  1  to ALU f_in.
- ex_valid  out  1  execute latch holds a live instruction.
- alu_rslt  in  DW  from ALU.
- alu_out  in  1  from ALU flag.
- dbg_r1  out  DW  current R1 contents.

Behaviour:
- Reset (rst_n=0 at an edge):
  - all registers become 0; ex_valid=0.
  - alu_cmd=NOP_CMD; alu_a=alu_b=0; alu_fin=0.
  - in_ready=1 in the cycle after reset.
  - A reset mid-operation discards the EX instruction with no writeback.
- in_ready:
  - with FWD_EN: in_ready = !ex_stall.
  - without FWD_EN: see Optional Feature.
- Accept = in_valid && in_ready && !flush.
- On Accept:
  - the EX latch loads cmd, operands, wr_en, dest, flag_wr; ex_valid=1.
  - Operands are read through the bypass.
- When in_ready=1 and no Accept, the EX latch loads a bubble: ex_valid=0, alu_cmd=NOP_CMD.
- When ex_stall=1, the EX latch and all outputs hold.
- Writeback occurs at the edge where ex_valid=1 && !ex_stall, exactly once per instruction:
  - if wr_en: R[dest] <= alu_rslt.
  - if flag_wr: R1 <= {7'b0, alu_out}.
  - If dest==1 and flag_wr are both set, the flag write wins.
- Latency: one edge from accept to ALU inputs; writeback at the following edge (2 edges accept→register update).
- alu_fin = R1[0] sampled at accept, bypassed like any other operand.
- Bypass: if the EX instruction writes register X at the same edge an operand read of X is latched, the latched operand takes the value being written (flag value for R1 when flag_wr).
- R0 is an ordinary writable register; there is no hardwired zero.
- flush and in_valid=0 both produce a bubble. flush does not affect the EX instruction currently writing back.
- dbg_r1 reflects R1 after writeback (registered value).

Optional Feature:
- Macro FWD_EN.
- Defined: the bypass described above is present; in_ready = !ex_stall.
- Undefined: no bypass. in_ready = !ex_stall && !hazard, where hazard = ex_valid and any source of the issuing instruction matches the EX write target:
  - r(4+rd_idx) is always a source;
  - r(rs_idx) is a source when use_imm=0;
  - R1 is always a source, via f_in.
- Undefined case: EX write targets are dest if wr_en, and R1 if flag_wr.
- Undefined case: a hazard inserts exactly one bubble; the instruction issues next cycle reading the written register file.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → ex_valid=0, alu_cmd=1111, all registers 0, in_ready=1 after release.
- Write then read: issue a write of 8'h5A to r5 (alu_rslt=5A); next instruction reads rd_idx=1 →
  - FWD_EN: alu_a=5A the cycle after issue.
  - no FWD_EN: in_ready=0 for one cycle, then alu_a=5A.
- Flag path: alu_out=1 with flag_wr=1; next instruction cmd=0111 → alu_fin=1 and R1=8'h01. Also dest=1, wr_en=1, alu_rslt=8'hFF with flag_wr=1, alu_out=0 → R1=8'h00.
- Immediate select: in_use_imm=1, in_imm=8'hFE, rs_idx=2 with r2=8'h33 → alu_b=FE. With use_imm=0 → alu_b=33.
- Stall: assert ex_stall for 3 cycles with an instruction in EX → outputs constant, in_ready=0, single writeback after release (register written once).
- Flush: in_valid=1, flush=1 while EX writes r6=8'h11 → r6 updates to 11, next ex_valid=0, alu_cmd=1111.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : Operand-fetch stage feeding the ALU: 8-entry register file,
//            execute latch with stall/flush, writeback of ALU result/flag.
//            Optional macro FWD_EN enables the operand bypass; without it a
//            one-bubble hazard interlock is used instead.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_stage #(
    parameter int         DW      = 8,
    parameter int         NREG    = 8,
    parameter logic [3:0] NOP_CMD = 4'b1111
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_cmd,
    input  logic [1:0]    in_rd_idx,
    input  logic [1:0]    in_rs_idx,
    input  logic [DW-1:0] in_imm,
    input  logic          in_use_imm,
    input  logic          in_wr_en,
    input  logic [2:0]    in_dest,
    input  logic          in_flag_wr,
    input  logic          ex_stall,
    input  logic          flush,
    output logic [3:0]    alu_cmd,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_fin,
    output logic          ex_valid,
    input  logic [DW-1:0] alu_rslt,
    input  logic          alu_out,
    output logic [DW-1:0] dbg_r1
);

    logic [DW-1:0] r_regs [NREG];

    logic          r_ex_valid;
    logic [3:0]    r_ex_cmd;
    logic [DW-1:0] r_ex_a;
    logic [DW-1:0] r_ex_b;
    logic          r_ex_fin;
    logic          r_ex_wr_en;
    logic [2:0]    r_ex_dest;
    logic          r_ex_flag_wr;

    logic          w_wb;
    logic          w_accept;
    logic          w_hazard;
    logic [DW-1:0] w_regs_nx [NREG];
    logic [DW-1:0] w_src     [NREG];
    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_op_b;
    logic          w_op_fin;

    assign w_wb = r_ex_valid && !ex_stall;

    // Register file contents after this edge's writeback; flag write to R1 wins.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_regs_nx[i] = r_regs[i];
            if (w_wb && r_ex_wr_en && (r_ex_dest == 3'(i))) begin
                w_regs_nx[i] = alu_rslt;
            end
            if (w_wb && r_ex_flag_wr && (i == 1)) begin
                w_regs_nx[i] = {{(DW-1){1'b0}}, alu_out};
            end
        end
    end

`ifdef FWD_EN
    // Reading the post-writeback view is the bypass.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_src[i] = w_regs_nx[i];
        end
    end

    assign w_hazard = 1'b0;
`else
    logic w_hit_dest;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_src[i] = r_regs[i];
        end
    end

    // R1 is always a source through f_in, so any flag write in EX is a hazard.
    assign w_hit_dest = r_ex_wr_en &&
                        ((r_ex_dest == {1'b1, in_rd_idx}) ||
                         (!in_use_imm && (r_ex_dest == {1'b0, in_rs_idx})) ||
                         (r_ex_dest == 3'd1));
    assign w_hazard   = r_ex_valid && (w_hit_dest || r_ex_flag_wr);
`endif

    assign in_ready = !ex_stall && !w_hazard;
    assign w_accept = in_valid && in_ready && !flush;

    assign w_op_a   = w_src[{1'b1, in_rd_idx}];
    assign w_op_b   = in_use_imm ? in_imm : w_src[{1'b0, in_rs_idx}];
    assign w_op_fin = w_src[1][0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_ex_valid   <= 1'b0;
            r_ex_cmd     <= NOP_CMD;
            r_ex_a       <= '0;
            r_ex_b       <= '0;
            r_ex_fin     <= 1'b0;
            r_ex_wr_en   <= 1'b0;
            r_ex_dest    <= '0;
            r_ex_flag_wr <= 1'b0;
        end else if (!ex_stall) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= w_regs_nx[i];
            end
            if (w_accept) begin
                r_ex_valid   <= 1'b1;
                r_ex_cmd     <= in_cmd;
                r_ex_a       <= w_op_a;
                r_ex_b       <= w_op_b;
                r_ex_fin     <= w_op_fin;
                r_ex_wr_en   <= in_wr_en;
                r_ex_dest    <= in_dest;
                r_ex_flag_wr <= in_flag_wr;
            end else begin
                r_ex_valid   <= 1'b0;
                r_ex_cmd     <= NOP_CMD;
                r_ex_a       <= '0;
                r_ex_b       <= '0;
                r_ex_fin     <= 1'b0;
                r_ex_wr_en   <= 1'b0;
                r_ex_dest    <= '0;
                r_ex_flag_wr <= 1'b0;
            end
        end
    end

    assign ex_valid = r_ex_valid;
    assign alu_cmd  = r_ex_cmd;
    assign alu_a    = r_ex_a;
    assign alu_b    = r_ex_b;
    assign alu_fin  = r_ex_fin;
    assign dbg_r1   = r_regs[1];

endmodule

`default_nettype wire
